ex_mc_controller: RTL and testbench
===================================

# ex_mc_controller

Execution-stage controller for RV32IM with multi-cycle multiply and divide support. It decodes ALU control combinationally and sequences the multiply unit (MU, fixed latency) and divide unit (DU, done handshake). It stalls the front of the pipeline while a multi-cycle op is in flight and drives the EX result-mux select. It sits between the ID/EX pipeline register and the ALU/MU/DU datapath, and succeeds the purely combinational EX decoder.

## Interface
- MUL_LAT, 2, MU latency in cycles from start to result; legal range 1..15.
- DIV_EN, 1, 1 = divide ops sequenced on the DU; 0 = divide ops flagged illegal.
- DIV_MAX, 64, watchdog limit on DU busy cycles; legal range 2..255.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  EX holds a valid instruction.
- opcode  input  7  instruction opcode.
- func3  input  3  instruction func3.
- func7b50  input  2  func7 bits {5,0}.
- flush  input  1  synchronous pipeline flush.
- div_done  input  1  DU result ready, single-cycle pulse.
- aluctl  output  4  ALU operation select, combinational.
- mulctl  output  2  MU op: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu.
- mulstart  output  1  one-cycle MU start pulse.
- divctl  output  2  DU op: 00 div, 01 divu, 10 rem, 11 remu.
- divstart  output  1  one-cycle DU start pulse.
- ifuresctl  output  2  result-mux select: 0 ALU, 1 MU, 2 DU.
- res_valid  output  1  EX result valid this cycle.
- stall  output  1  hold IF/ID/EX registers.
- illegal  output  1  one-cycle pulse on an unsupported M op.
- div_err  output  1  one-cycle pulse on DU watchdog expiry.

## Operation
- **ALU decode.** Applies when opcode matches 0?10011. func3 maps to aluctl as follows:
  - 000 → {000, func7b50[1]}, but only for R-type (opcode[5]=1); I-type addi gives 0000.
  - 001 → 0101; 010 → 1000; 011 → 1001; 100 → 0010.
  - 101 → {011, func7b50[1]}; 110 → 0011; 111 → 0100.
  - Any other opcode gives 0100. No latches.
- **Op classes.**
  - is_m: opcode == 0110011 and func7b50 == 01.
  - is_mul: is_m and func3[2] == 0.
  - is_div: is_m and func3[2] == 1.
  - Everything else is an ALU op.
- **Issue condition.** issue = in_valid & ~flush & state == IDLE.
- **FSM states:** IDLE, MUL, DIV.
- **IDLE:**
  - issue & is_mul: mulstart = 1, stall = 1, load cnt = MUL_LAT-1, capture func3[1:0], go to MUL.
  - issue & is_div & DIV_EN: divstart = 1, stall = 1, clear wd = 0, capture func3[1:0], go to DIV.
  - issue & is_div & ~DIV_EN: illegal = 1, res_valid = 1, ifuresctl = 0, stay in IDLE.
  - issue & ALU op: res_valid = 1, ifuresctl = 0, stall = 0.
- **MUL:**
  - cnt != 0: stall = 1, decrement cnt.
  - cnt == 0: res_valid = 1, ifuresctl = 1, stall = 0, go to IDLE.
- **DIV:**
  - div_done: res_valid = 1, ifuresctl = 2, stall = 0, go to IDLE.
  - Otherwise: stall = 1 and wd increments.
  - wd == DIV_MAX-1 with no div_done: div_err = 1, res_valid = 0, stall = 0, go to IDLE.
- **mulctl / divctl.** Driven from func3[1:0] in the issue cycle and from the captured value while busy. They read 00 in IDLE when not issuing.
- **flush:**
  - In MUL or DIV: go to IDLE next edge; res_valid = 0 and stall = 0 that cycle.
  - In IDLE: suppresses the start pulses and res_valid.
- div_done is ignored outside DIV.
- The in_valid op is re-presented while stalled; it is never re-issued because issue requires IDLE.

## Timing
- **Reset values.** rst_n low asynchronously forces state = IDLE, cnt = 0, wd = 0, captured op = 00. Every registered or state-derived output is 0: mulctl, mulstart, divctl, divstart, ifuresctl, res_valid, stall, illegal, div_err. aluctl follows its combinational decode.
- **Reset mid-op** aborts the operation with no result.
- **ALU op:** 0-cycle latency; res_valid in the issue cycle.
- **MUL issued at cycle T:**
  - stall = 1 for cycles T .. T+MUL_LAT-1.
  - res_valid and ifuresctl = 1 at T+MUL_LAT.
  - Next issue is possible at T+MUL_LAT+1.
- **DIV issued at T with div_done at T+k (k ≥ 1):** stall = 1 for T .. T+k-1, res_valid at T+k.
- **DIV watchdog:** div_err fires at T+DIV_MAX if no div_done arrives.
- **Simultaneous events:**
  - div_done and wd expiry in the same cycle: done wins.
  - flush with cnt == 0 or div_done in the same cycle: flush wins, no res_valid.
- All start, illegal and div_err pulses are exactly one cycle wide.

## Test plan
- **ALU decode.** R-type sub (func3 000, func7b50 10) → aluctl 0001, res_valid 1, stall 0. addi with func7b50 10 → aluctl 0000. opcode 0000011 → aluctl 0100.
- **MUL latency.** MUL_LAT = 3, mulhu issued at T → mulstart only at T, mulctl 11 for T..T+3, stall T..T+2, res_valid and ifuresctl = 1 at T+3, back-to-back ALU op completes at T+4.
- **DIV handshake.** DIV_EN = 1, rem at T, div_done at T+5 → divstart only at T, divctl 10, stall T..T+4, res_valid and ifuresctl = 2 at T+5. A div_done pulse in IDLE beforehand produces no effect.
- **Watchdog.** DIV_MAX = 8, div with no div_done → div_err at T+8, stall 0, state IDLE, res_valid 0. Case where div_done coincides with expiry → res_valid 1, no div_err.
- **Flush.** Flush at T+1 of a MUL_LAT = 4 op → IDLE at T+2, no res_valid. Flush together with in_valid & is_div in IDLE → no divstart.
- **Reset and DIV_EN = 0.** rst_n low mid-DIV → all outputs 0 immediately. With DIV_EN = 0, a divu issue → illegal pulse, res_valid 1, ifuresctl 0, no divstart.

Source files
------------

// File: rtl/ex_mc_controller.sv
// ---------------------------------------------------------------------------
// ex_mc_controller
// Execution-stage controller for RV32IM. Decodes the ALU operation
// combinationally, sequences the fixed-latency multiply unit (MU) and the
// handshaked divide unit (DU), stalls the front of the pipeline while a
// multi-cycle op is in flight and drives the EX result-mux select.
//
// Parameters
//   MUL_LAT  MU latency in cycles from start to result (1..15)
//   DIV_EN   1: divides run on the DU, 0: divides are flagged illegal
//   DIV_MAX  watchdog limit on DU busy cycles (2..255)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            EX holds a valid instruction
//   opcode/func3/func7b50  instruction fields (func7 bits {5,0})
//   flush               synchronous pipeline flush
//   div_done            DU result ready pulse
//   aluctl              ALU operation select
//   mulctl/mulstart     MU operation and start pulse
//   divctl/divstart     DU operation and start pulse
//   ifuresctl           result-mux select: 0 ALU, 1 MU, 2 DU
//   res_valid           EX result valid this cycle
//   stall               hold IF/ID/EX registers
//   illegal             unsupported M op pulse
//   div_err             DU watchdog expiry pulse
// ---------------------------------------------------------------------------
module ex_mc_controller #(
    parameter int MUL_LAT = 2,
    parameter bit DIV_EN  = 1'b1,
    parameter int DIV_MAX = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [1:0] func7b50,
    input  logic       flush,
    input  logic       div_done,
    output logic [3:0] aluctl,
    output logic [1:0] mulctl,
    output logic       mulstart,
    output logic [1:0] divctl,
    output logic       divstart,
    output logic [1:0] ifuresctl,
    output logic       res_valid,
    output logic       stall,
    output logic       illegal,
    output logic       div_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
    localparam logic [7:0] WD_LAST  = 8'(DIV_MAX - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] wd_q, wd_d;
    logic [1:0] op_q, op_d;

    logic is_m_s;
    logic is_mul_s;
    logic is_div_s;
    logic issue_s;

    // Op classification and issue qualification
    assign is_m_s   = (opcode == 7'b0110011) && (func7b50 == 2'b01);
    assign is_mul_s = is_m_s & ~func3[2];
    assign is_div_s = is_m_s & func3[2];
    // rst_n gates issue so every state-derived output reads 0 while reset is held
    assign issue_s  = rst_n & in_valid & ~flush & (state_q == ST_IDLE);

    // ALU operation decode for OP / OP-IMM
    always_comb begin
        aluctl = 4'b0100;
        if ((opcode[6] == 1'b0) && (opcode[4:0] == 5'b10011)) begin
            case (func3)
                3'b000:  aluctl = {3'b000, func7b50[1] & opcode[5]};
                3'b001:  aluctl = 4'b0101;
                3'b010:  aluctl = 4'b1000;
                3'b011:  aluctl = 4'b1001;
                3'b100:  aluctl = 4'b0010;
                3'b101:  aluctl = {3'b011, func7b50[1]};
                3'b110:  aluctl = 4'b0011;
                3'b111:  aluctl = 4'b0100;
                default: aluctl = 4'b0100;
            endcase
        end else begin
            aluctl = 4'b0100;
        end
    end

    // Sequencer next-state and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        op_d      = op_q;
        mulctl    = 2'b00;
        mulstart  = 1'b0;
        divctl    = 2'b00;
        divstart  = 1'b0;
        ifuresctl = 2'd0;
        res_valid = 1'b0;
        stall     = 1'b0;
        illegal   = 1'b0;
        div_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    if (is_mul_s) begin
                        mulstart = 1'b1;
                        mulctl   = func3[1:0];
                        stall    = 1'b1;
                        cnt_d    = MUL_LOAD;
                        op_d     = func3[1:0];
                        state_d  = ST_MUL;
                    end else if (is_div_s) begin
                        if (DIV_EN) begin
                            divstart = 1'b1;
                            divctl   = func3[1:0];
                            stall    = 1'b1;
                            wd_d     = 8'd0;
                            op_d     = func3[1:0];
                            state_d  = ST_DIV;
                        end else begin
                            // Divide not supported: retire as an ALU-path no-op
                            illegal   = 1'b1;
                            res_valid = 1'b1;
                        end
                    end else begin
                        res_valid = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                mulctl = op_q;
                if (flush) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_valid = 1'b1;
                    ifuresctl = 2'd1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DIV: begin
                divctl = op_q;
                // Priority: flush, then done, then watchdog expiry
                if (flush) begin
                    wd_d    = 8'd0;
                    state_d = ST_IDLE;
                end else if (div_done) begin
                    res_valid = 1'b1;
                    ifuresctl = 2'd2;
                    wd_d      = 8'd0;
                    state_d   = ST_IDLE;
                end else if (wd_q == WD_LAST) begin
                    div_err = 1'b1;
                    wd_d    = 8'd0;
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    wd_d  = wd_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state, latency counter, watchdog and captured op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wd_q    <= 8'd0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            op_q    <= op_d;
        end
    end

endmodule

// File: tb/tb_ex_mc_controller.sv
module tb_ex_mc_controller;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;

    logic       clk;
    logic       rst_n;
    logic       in_valid_a;
    logic       in_valid_b;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [1:0] func7b50;
    logic       flush;
    logic       div_done;

    logic [3:0] aluctl_a, aluctl_b;
    logic [1:0] mulctl_a, mulctl_b, divctl_a, divctl_b, ifuresctl_a, ifuresctl_b;
    logic       mulstart_a, mulstart_b, divstart_a, divstart_b;
    logic       res_valid_a, res_valid_b, stall_a, stall_b;
    logic       illegal_a, illegal_b, div_err_a, div_err_b;

    logic [15:0] vec_a;
    logic [15:0] vec_b;

    logic [15:0] sb_q[$];
    int          n_vec;
    int          n_err;

    assign vec_a = {aluctl_a, mulctl_a, mulstart_a, divctl_a, divstart_a,
                    ifuresctl_a, res_valid_a, stall_a, illegal_a, div_err_a};
    assign vec_b = {aluctl_b, mulctl_b, mulstart_b, divctl_b, divstart_b,
                    ifuresctl_b, res_valid_b, stall_b, illegal_b, div_err_b};

    ex_mc_controller #(.MUL_LAT(3), .DIV_EN(1'b1), .DIV_MAX(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .opcode(opcode),
        .func3(func3), .func7b50(func7b50), .flush(flush), .div_done(div_done),
        .aluctl(aluctl_a), .mulctl(mulctl_a), .mulstart(mulstart_a),
        .divctl(divctl_a), .divstart(divstart_a), .ifuresctl(ifuresctl_a),
        .res_valid(res_valid_a), .stall(stall_a), .illegal(illegal_a),
        .div_err(div_err_a)
    );

    ex_mc_controller #(.MUL_LAT(4), .DIV_EN(1'b0), .DIV_MAX(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .opcode(opcode),
        .func3(func3), .func7b50(func7b50), .flush(flush), .div_done(div_done),
        .aluctl(aluctl_b), .mulctl(mulctl_b), .mulstart(mulstart_b),
        .divctl(divctl_b), .divstart(divstart_b), .ifuresctl(ifuresctl_b),
        .res_valid(res_valid_b), .stall(stall_b), .illegal(illegal_b),
        .div_err(div_err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack an expected output vector in the same field order as vec_a/vec_b
    function automatic logic [15:0] ev(input logic [3:0] alu, input logic [1:0] mc,
                                       input logic ms, input logic [1:0] dc,
                                       input logic ds, input logic [1:0] ir,
                                       input logic rv, input logic st,
                                       input logic il, input logic de);
        return {alu, mc, ms, dc, ds, ir, rv, st, il, de};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp_v, $time);
        end
    endtask

    // One cycle: drive at negedge, queue expectation, compare before the next posedge
    task automatic cyc(input string tag, input logic sel, input logic rst,
                       input logic iv, input logic [6:0] op, input logic [2:0] f3,
                       input logic [1:0] f7, input logic fl, input logic dd,
                       input logic [15:0] e);
        logic [15:0] exp_v;
        @(negedge clk);
        rst_n      = rst;
        in_valid_a = sel ? 1'b0 : iv;
        in_valid_b = sel ? iv : 1'b0;
        opcode     = op;
        func3      = f3;
        func7b50   = f7;
        flush      = fl;
        div_done   = dd;
        sb_q.push_back(e);
        #2;
        exp_v = sb_q.pop_front();
        check_eq(tag, sel ? vec_b : vec_a, exp_v);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        opcode     = 7'd0;
        func3      = 3'd0;
        func7b50   = 2'd0;
        flush      = 1'b0;
        div_done   = 1'b0;

        // Reset state with a valid sub presented
        cyc("reset", 1'b0, 1'b0, 1'b1, OP_R, 3'b000, 2'b10, 1'b0, 1'b0,
            ev(4'b0001, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // ALU decode
        cyc("alu_sub", 1'b0, 1'b1, 1'b1, OP_R, 3'b000, 2'b10, 1'b0, 1'b0,
            ev(4'b0001, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("alu_addi", 1'b0, 1'b1, 1'b1, OP_I, 3'b000, 2'b10, 1'b0, 1'b0,
            ev(4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("alu_load", 1'b0, 1'b1, 1'b1, OP_LD, 3'b000, 2'b00, 1'b0, 1'b0,
            ev(4'b0100, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("alu_sra", 1'b0, 1'b1, 1'b1, OP_R, 3'b101, 2'b10, 1'b0, 1'b0,
            ev(4'b0111, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("alu_slti", 1'b0, 1'b1, 1'b1, OP_I, 3'b010, 2'b00, 1'b0, 1'b0,
            ev(4'b1000, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("alu_slli", 1'b0, 1'b1, 1'b1, OP_I, 3'b001, 2'b00, 1'b0, 1'b0,
            ev(4'b0101, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        // div_done in IDLE has no effect
        cyc("done_idle", 1'b0, 1'b1, 1'b0, OP_LD, 3'b000, 2'b00, 1'b0, 1'b1,
            ev(4'b0100, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // mulhu, MUL_LAT = 3
        cyc("mul_issue", 1'b0, 1'b1, 1'b1, OP_R, 3'b011, 2'b01, 1'b0, 1'b0,
            ev(4'b1001, 2'b11, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++)
            cyc("mul_busy", 1'b0, 1'b1, 1'b1, OP_R, 3'b011, 2'b01, 1'b0, 1'b0,
                ev(4'b1001, 2'b11, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("mul_done", 1'b0, 1'b1, 1'b1, OP_R, 3'b011, 2'b01, 1'b0, 1'b0,
            ev(4'b1001, 2'b11, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("mul_b2b_alu", 1'b0, 1'b1, 1'b1, OP_R, 3'b000, 2'b00, 1'b0, 1'b0,
            ev(4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // rem with div_done at T+5
        cyc("div_issue", 1'b0, 1'b1, 1'b1, OP_R, 3'b110, 2'b01, 1'b0, 1'b0,
            ev(4'b0011, 2'd0, 1'b0, 2'b10, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++)
            cyc("div_busy", 1'b0, 1'b1, 1'b1, OP_R, 3'b110, 2'b01, 1'b0, 1'b0,
                ev(4'b0011, 2'd0, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("div_done", 1'b0, 1'b1, 1'b1, OP_R, 3'b110, 2'b01, 1'b0, 1'b1,
            ev(4'b0011, 2'd0, 1'b0, 2'b10, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("div_idle", 1'b0, 1'b1, 1'b0, OP_R, 3'b110, 2'b01, 1'b0, 1'b0,
            ev(4'b0011, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // divu watchdog expiry, DIV_MAX = 8
        cyc("wd_issue", 1'b0, 1'b1, 1'b1, OP_R, 3'b101, 2'b01, 1'b0, 1'b0,
            ev(4'b0110, 2'd0, 1'b0, 2'b01, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++)
            cyc("wd_busy", 1'b0, 1'b1, 1'b1, OP_R, 3'b101, 2'b01, 1'b0, 1'b0,
                ev(4'b0110, 2'd0, 1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("wd_expire", 1'b0, 1'b1, 1'b1, OP_R, 3'b101, 2'b01, 1'b0, 1'b0,
            ev(4'b0110, 2'd0, 1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        cyc("wd_idle", 1'b0, 1'b1, 1'b0, OP_R, 3'b101, 2'b01, 1'b0, 1'b0,
            ev(4'b0110, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // div_done coincides with watchdog expiry: done wins
        cyc("wdc_issue", 1'b0, 1'b1, 1'b1, OP_R, 3'b101, 2'b01, 1'b0, 1'b0,
            ev(4'b0110, 2'd0, 1'b0, 2'b01, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++)
            cyc("wdc_busy", 1'b0, 1'b1, 1'b1, OP_R, 3'b101, 2'b01, 1'b0, 1'b0,
                ev(4'b0110, 2'd0, 1'b0, 2'b01, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("wdc_done", 1'b0, 1'b1, 1'b1, OP_R, 3'b101, 2'b01, 1'b0, 1'b1,
            ev(4'b0110, 2'd0, 1'b0, 2'b01, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc("wdc_idle", 1'b0, 1'b1, 1'b0, OP_R, 3'b101, 2'b01, 1'b0, 1'b0,
            ev(4'b0110, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // flush with a divide presented in IDLE
        cyc("flush_idle_div", 1'b0, 1'b1, 1'b1, OP_R, 3'b110, 2'b01, 1'b1, 1'b0,
            ev(4'b0011, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc("flush_idle_after", 1'b0, 1'b1, 1'b1, OP_R, 3'b000, 2'b00, 1'b0, 1'b0,
            ev(4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // reset asserted mid-DIV
        cyc("rst_div_issue", 1'b0, 1'b1, 1'b1, OP_R, 3'b110, 2'b01, 1'b0, 1'b0,
            ev(4'b0011, 2'd0, 1'b0, 2'b10, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("rst_div_busy", 1'b0, 1'b1, 1'b1, OP_R, 3'b110, 2'b01, 1'b0, 1'b0,
            ev(4'b0011, 2'd0, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("reset_mid_div", 1'b0, 1'b0, 1'b1, OP_R, 3'b110, 2'b01, 1'b0, 1'b0,
            ev(4'b0011, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc("reset_after_done", 1'b0, 1'b1, 1'b0, OP_R, 3'b110, 2'b01, 1'b0, 1'b1,
            ev(4'b0011, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        // DUT B: mulh, MUL_LAT = 4, full latency
        cyc("b_mul_issue", 1'b1, 1'b1, 1'b1, OP_R, 3'b001, 2'b01, 1'b0, 1'b0,
            ev(4'b0101, 2'b01, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            cyc("b_mul_busy", 1'b1, 1'b1, 1'b1, OP_R, 3'b001, 2'b01, 1'b0, 1'b0,
                ev(4'b0101, 2'b01, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("b_mul_done", 1'b1, 1'b1, 1'b1, OP_R, 3'b001, 2'b01, 1'b0, 1'b0,
            ev(4'b0101, 2'b01, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0));

        // DUT B: flush at T+1 of a MUL_LAT = 4 op
        cyc("b_fl_issue", 1'b1, 1'b1, 1'b1, OP_R, 3'b001, 2'b01, 1'b0, 1'b0,
            ev(4'b0101, 2'b01, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        cyc("b_fl_flush", 1'b1, 1'b1, 1'b1, OP_R, 3'b001, 2'b01, 1'b1, 1'b0,
            ev(4'b0101, 2'b01, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            cyc("b_fl_gone", 1'b1, 1'b1, 1'b0, OP_R, 3'b001, 2'b01, 1'b0, 1'b0,
                ev(4'b0101, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc("b_fl_alu", 1'b1, 1'b1, 1'b1, OP_R, 3'b000, 2'b00, 1'b0, 1'b0,
            ev(4'b0000, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));

        // DUT B: divide disabled, divu is illegal
        cyc("b_illegal", 1'b1, 1'b1, 1'b1, OP_R, 3'b101, 2'b01, 1'b0, 1'b0,
            ev(4'b0110, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        cyc("b_illegal_end", 1'b1, 1'b1, 1'b0, OP_R, 3'b101, 2'b01, 1'b0, 1'b0,
            ev(4'b0110, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
